pattern_pwm_decoder: RTL and testbench
======================================

Name: pattern_pwm_decoder

Overview:
- Receive-side counterpart of the pattern PWM/DAC generator.
- Samples a 1-bit pattern PWM line (comparator/ADC slicer output or loopback of pwm_out).
- Recovers each frame's bit pattern, checks it against an expected PAT, and tracks frame and error statistics.
- Used for loopback self-test of the DDS/DAC path and for decoding externally generated pattern bursts.

Parameters:
- _PAT_WIDTH, 8: maximum pattern bits per frame; width of pat_out/pat_expect.
- _SYNC_STAGES, 2: input synchronizer depth; must be ≥ 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- dec_en  in  1  decoder enable; low aborts any frame and holds IDLE
- pwm_in  in  1  asynchronous pattern PWM line
- duty_num  in  8  bit period minus 1 (each bit lasts duty_num+1 cycles)
- pat_len  in  4  bits per frame, 1.._PAT_WIDTH (0 treated as 1, >_PAT_WIDTH clamped)
- min_gap  in  16  minimum low cycles required between frames
- pat_expect  in  _PAT_WIDTH  expected pattern, LSB = first bit
- pat_out  out  _PAT_WIDTH  last decoded pattern, LSB first; unused upper bits 0
- pat_valid  out  1  1-cycle pulse when pat_out updates
- pat_match  out  1  pat_out == pat_expect (masked to pat_len); valid with pat_valid, held after
- gap_err  out  1  1-cycle pulse, frame started before min_gap elapsed
- frame_cnt  out  16  decoded frames, wraps at 0xFFFF→0
- err_cnt  out  8  mismatches + gap errors, saturates at 0xFF
- busy  out  1  high in ACTIVE

Behaviour:
- Reset (rst high at posedge): all outputs 0, state IDLE, synchronizer flops 0, counters 0. Reset wins over every other event.
- Input path: _SYNC_STAGES flops, then one edge-detect flop. A rise is seen 3 cycles after the pwm_in transition (default parameters).
- Configuration (duty_num, pat_len, min_gap, pat_expect) is latched on frame start and stays stable for the whole frame.
- States:
  - IDLE: wait for dec_en=1 and a sync rise → ACTIVE. bit_idx=0, cyc_cnt=0, shift reg cleared.
  - ACTIVE: cyc_cnt counts 0..duty_num. At cyc_cnt == duty_num>>1, sample the sync level into bit[bit_idx]. At cyc_cnt == duty_num: cyc_cnt=0. If bit_idx == pat_len-1 → GAP, else bit_idx+1.
  - GAP, on entry: pat_out updated, pat_valid=1, pat_match computed, frame_cnt+1. Mismatch → err_cnt+1.
  - GAP: gap_cnt increments while the line is low (saturates at 0xFFFF). On a sync rise:
    - gap_cnt < min_gap → gap_err=1, err_cnt+1, still start a new frame (→ ACTIVE).
    - Otherwise → ACTIVE, no error.
- dec_en=0 in any state → IDLE next cycle. No pat_valid for the partial frame. Counters hold.
- Mismatch and gap error in the same cycle cannot occur (different states). If both occur in one frame, err_cnt increments twice, on separate cycles.
- duty_num=0: 1-cycle bits, sample at cyc_cnt 0. Must decode correctly.
- Frame start requires first bit = 1 (generator PAT[0]=1). Patterns with PAT[0]=0 are out of protocol and not detected.
- Line high at dec_en rise (mid-frame join): no rise → waits. The first rise starts the frame.
- err_cnt at 0xFF: further errors leave it at 0xFF. frame_cnt wraps.
- Total latency: last bit's final cycle + 1 → pat_valid.

Decomposition:
- Shared package pattern_pkg: state encoding (IDLE/ACTIVE/GAP), the _PAT_WIDTH default, and the pat_len clamp function.
- Sub-module: pwm_in_sync (N-flop synchronizer + rise/fall detect). Reusable for any async pattern line.
- Rest is flat.

Test Plan:
- Loopback from generator, PAT=8'b0000_1011, duty_num=3, pat_len=4, min_gap=5, gap 10 cycles, 3 frames → 3 pat_valid pulses, pat_out=4'b1011, pat_match=1, frame_cnt=3, err_cnt=0.
- pat_expect=8'h0B, drive 1,1,1,1 (4 bits, duty_num=3) → pat_out=8'h0F, pat_match=0, err_cnt=1.
- Gap of 2 low cycles, min_gap=5 → gap_err pulse, err_cnt+1; next frame still decoded, pat_valid for it.
- dec_en dropped after bit 1 of 4 → IDLE, no pat_valid, frame_cnt unchanged. Re-enable plus a clean frame → decoded normally.
- duty_num=0, pat_len=8, pattern 8'b1010_0101 → pat_out=8'hA5, pat_valid 1 cycle after the last bit.
- 260 mismatching frames → err_cnt=0xFF (saturated), frame_cnt=260. Reset mid-frame → all outputs 0 next cycle.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern PWM receive path: decoder state
// encoding, default pattern width and the pattern-length clamp.
package pattern_pkg;

    localparam int unsigned PAT_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } dec_state_e;

    // Map a requested frame length onto 1..max_len (0 means one bit).
    function automatic logic [3:0] clamp_pat_len(input logic [3:0] len,
                                                 input logic [3:0] max_len);
        if (len == 4'd0) begin
            return 4'd1;
        end
        if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// Multi-flop synchronizer for an asynchronous 1-bit line followed by an
// edge-detect flop. level_o is the edge-detect flop itself, so it lines up
// with the cycle in which rise_o was reported: the cycle after a rise,
// level_o shows the first high sample of the line.
module pwm_in_sync #(
    parameter int unsigned STAGES = 2  // must be >= 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              edge_q;

    // Shift the async line through the synchronizer, then the edge flop.
    always_ff @(posedge clk) begin
        // NOTE: synchronous reset -- rst is only looked at on the clock edge,
        // so it must be held across at least one rising edge to take effect.
        if (rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the
            // previous value of its neighbour, forming a true shift chain.
            sync_q <= {sync_q[STAGES-2:0], async_i};
            edge_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = edge_q;
    assign rise_o  = sync_q[STAGES-1] & ~edge_q;

endmodule

// File: rtl/pattern_pwm_decoder.sv
// Receive-side decoder for the pattern PWM line: recovers each frame's
// bit pattern, compares it with the expected pattern and keeps frame,
// mismatch and inter-frame gap statistics.
module pattern_pwm_decoder
    import pattern_pkg::*;
#(
    parameter int unsigned PAT_WIDTH   = PAT_WIDTH_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_en,
    input  logic                 pwm_in,
    input  logic [7:0]           duty_num,
    input  logic [3:0]           pat_len,
    input  logic [15:0]          min_gap,
    input  logic [PAT_WIDTH-1:0] pat_expect,
    output logic [PAT_WIDTH-1:0] pat_out,
    output logic                 pat_valid,
    output logic                 pat_match,
    output logic                 gap_err,
    output logic [15:0]          frame_cnt,
    output logic [7:0]           err_cnt,
    output logic                 busy
);

    logic line_level;
    logic line_rise;

    pwm_in_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (pwm_in),
        .level_o (line_level),
        .rise_o  (line_rise)
    );

    dec_state_e           state_q, state_d;
    logic [7:0]           cyc_q, cyc_d;
    logic [3:0]           bit_q, bit_d;
    logic [PAT_WIDTH-1:0] shift_q, shift_d;
    logic [15:0]          gap_q, gap_d;
    // Per-frame configuration snapshot.
    logic [7:0]           duty_q, duty_d;
    logic [3:0]           len_q, len_d;
    logic [15:0]          min_gap_q, min_gap_d;
    logic [PAT_WIDTH-1:0] expect_q, expect_d;
    // Output registers.
    logic [PAT_WIDTH-1:0] pat_out_q, pat_out_d;
    logic                 pat_valid_q, pat_valid_d;
    logic                 pat_match_q, pat_match_d;
    logic                 gap_err_q, gap_err_d;
    logic [15:0]          frame_q, frame_d;
    logic [7:0]           err_q, err_d;

    logic                 start_frame;
    logic                 is_match;
    logic [PAT_WIDTH-1:0] bit_sel;
    logic [PAT_WIDTH-1:0] len_mask;
    logic [16:0]          gap_next;
    logic [7:0]           err_sat;

    assign bit_sel  = PAT_WIDTH'(1) << bit_q;
    // len_q == PAT_WIDTH wraps the shift to zero, giving an all-ones mask.
    assign len_mask = (PAT_WIDTH'(1) << len_q) - PAT_WIDTH'(1);
    // Low cycles in GAP including the current one (the cycle before a rise
    // is always low).
    assign gap_next = {1'b0, gap_q} + 17'd1;
    assign err_sat  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            gap_q       <= '0;
            duty_q      <= '0;
            len_q       <= 4'd1;
            min_gap_q   <= '0;
            expect_q    <= '0;
            pat_out_q   <= '0;
            pat_valid_q <= 1'b0;
            pat_match_q <= 1'b0;
            gap_err_q   <= 1'b0;
            frame_q     <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            gap_q       <= gap_d;
            duty_q      <= duty_d;
            len_q       <= len_d;
            min_gap_q   <= min_gap_d;
            expect_q    <= expect_d;
            pat_out_q   <= pat_out_d;
            pat_valid_q <= pat_valid_d;
            pat_match_q <= pat_match_d;
            gap_err_q   <= gap_err_d;
            frame_q     <= frame_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic: bit timing, frame completion, gap checking.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        cyc_d       = cyc_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        gap_d       = gap_q;
        duty_d      = duty_q;
        len_d       = len_q;
        min_gap_d   = min_gap_q;
        expect_d    = expect_q;
        pat_out_d   = pat_out_q;
        pat_valid_d = 1'b0;
        pat_match_d = pat_match_q;
        gap_err_d   = 1'b0;
        frame_d     = frame_q;
        err_d       = err_q;
        start_frame = 1'b0;
        is_match    = 1'b0;

        if (!dec_en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (line_rise) begin
                        start_frame = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (cyc_q == (duty_q >> 1) && line_level) begin
                        shift_d = shift_q | bit_sel;
                    end
                    if (cyc_q == duty_q) begin
                        cyc_d = '0;
                        if (bit_q == len_q - 4'd1) begin
                            // shift_d already holds a last bit sampled this cycle.
                            is_match    = ((shift_d ^ expect_q) & len_mask) == '0;
                            state_d     = ST_GAP;
                            gap_d       = '0;
                            pat_out_d   = shift_d;
                            pat_valid_d = 1'b1;
                            pat_match_d = is_match;
                            frame_d     = frame_q + 16'd1;
                            if (!is_match) begin
                                err_d = err_sat;
                            end
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else begin
                        cyc_d = cyc_q + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (line_rise) begin
                        if (gap_next < {1'b0, min_gap_q}) begin
                            gap_err_d = 1'b1;
                            err_d     = err_sat;
                        end
                        start_frame = 1'b1;
                    end else if (!line_level && gap_q != 16'hFFFF) begin
                        gap_d = gap_q + 16'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (start_frame) begin
                state_d   = ST_ACTIVE;
                cyc_d     = '0;
                bit_d     = '0;
                shift_d   = '0;
                duty_d    = duty_num;
                len_d     = clamp_pat_len(pat_len, 4'(PAT_WIDTH));
                min_gap_d = min_gap;
                expect_d  = pat_expect;
            end
        end
    end

    assign pat_out   = pat_out_q;
    assign pat_valid = pat_valid_q;
    assign pat_match = pat_match_q;
    assign gap_err   = gap_err_q;
    assign frame_cnt = frame_q;
    assign err_cnt   = err_q;
    assign busy      = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_pattern_pwm_decoder.sv
// Testbench for pattern_pwm_decoder: directed vector table, hand-written
// multi-cycle sequences and a randomized waveform checked against a
// frame-level reference model.
module tb_pattern_pwm_decoder;

    localparam int W = 8;
    localparam int SYNC_LAT = 3;  // line sample index -> cycle it is acted on

    logic        clk = 1'b0;
    logic        rst, dec_en, pwm_in;
    logic [7:0]  duty_num;
    logic [3:0]  pat_len;
    logic [15:0] min_gap;
    logic [7:0]  pat_expect;
    logic [7:0]  pat_out;
    logic        pat_valid, pat_match, gap_err, busy;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    pattern_pwm_decoder dut (
        .clk(clk), .rst(rst), .dec_en(dec_en), .pwm_in(pwm_in),
        .duty_num(duty_num), .pat_len(pat_len), .min_gap(min_gap),
        .pat_expect(pat_expect), .pat_out(pat_out), .pat_valid(pat_valid),
        .pat_match(pat_match), .gap_err(gap_err), .frame_cnt(frame_cnt),
        .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int tick     = 0;   // index of the line sample currently on pwm_in

    typedef struct {
        int         t;
        logic [7:0] p;
        logic       m;
    } ev_t;

    ev_t ev_q[$];
    int  gerr_q[$];
    int  valid_pulses = 0;
    int  gap_pulses   = 0;
    int  last_valid_tick = 0;
    int  last_gerr_tick  = 0;

    // Monitor: record output pulses on the falling edge.
    always @(negedge clk) begin
        if (pat_valid) begin
            ev_t e;
            e.t = tick;
            e.p = pat_out;
            e.m = pat_match;
            ev_q.push_back(e);
            valid_pulses++;
            last_valid_tick = tick;
        end
        if (gap_err) begin
            gerr_q.push_back(tick);
            gap_pulses++;
            last_gerr_tick = tick;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic int model_len(input int raw);
        if (raw == 0) return 1;
        if (raw > W) return W;
        return raw;
    endfunction

    task automatic drive(input logic v);
        @(posedge clk);
        #1;
        pwm_in = v;
        tick++;
    endtask

    task automatic drive_low(input int n);
        for (int i = 0; i < n; i++) drive(1'b0);
    endtask

    task automatic drive_frame(input logic [7:0] pat, input int len_raw, input int duty);
        for (int k = 0; k < model_len(len_raw); k++)
            for (int j = 0; j <= duty; j++) drive(pat[k]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_low(3);
        rst = 1'b0;
    endtask

    task automatic set_cfg(input int duty, input int len, input int gap, input int expv);
        duty_num   = 8'(duty);
        pat_len    = 4'(len);
        min_gap    = 16'(gap);
        pat_expect = 8'(expv);
    endtask

    // Random-phase waveform and the configuration present at each sample.
    bit line_q[$];
    int cd_q[$], cl_q[$], cm_q[$], ce_q[$];
    int cur_duty, cur_len, cur_mg, cur_exp;

    task automatic rnd_drive(input bit v);
        drive(v);
        line_q.push_back(v);
        cd_q.push_back(cur_duty);
        cl_q.push_back(cur_len);
        cm_q.push_back(cur_mg);
        ce_q.push_back(cur_exp);
    endtask

    typedef struct {
        int pat;
        int len;
        int duty;
        int exp_in;
        int gap;
        int exp_pat;
        int exp_match;
    } vec_t;

    vec_t vecs[8];

    int exp_frames = 0;
    int exp_errs   = 0;

    initial begin
        int vp, gp, end_tick, s2;
        ev_t xq[$];
        int  xg[$];
        int  m_frames, m_errs;

        vecs[0] = '{8'h0B, 4,  3, 8'h0B, 4, 8'h0B, 1};  // loopback frames
        vecs[1] = '{8'h0B, 4,  3, 8'h0B, 4, 8'h0B, 1};
        vecs[2] = '{8'h0B, 4,  3, 8'h0B, 4, 8'h0B, 1};
        vecs[3] = '{8'h0F, 4,  3, 8'h0B, 4, 8'h0F, 0};  // mismatch
        vecs[4] = '{8'hA5, 8,  0, 8'hA5, 4, 8'hA5, 1};  // 1-cycle bits
        vecs[5] = '{8'hFF, 0,  1, 8'h01, 4, 8'h01, 1};  // len 0 -> 1 bit
        vecs[6] = '{8'hC3, 12, 2, 8'hC3, 4, 8'hC3, 1};  // len clamped to 8
        vecs[7] = '{8'h05, 3,  1, 8'hFD, 5, 8'h05, 1};  // compare masked to len

        pwm_in = 1'b0;
        dec_en = 1'b0;
        set_cfg(3, 4, 5, 8'h0B);
        do_reset();
        check("reset_pat_out",   32'(pat_out), 0);
        check("reset_valid",     32'(pat_valid), 0);
        check("reset_match",     32'(pat_match), 0);
        check("reset_frame_cnt", 32'(frame_cnt), 0);
        check("reset_err_cnt",   32'(err_cnt), 0);
        check("reset_busy",      32'(busy), 0);
        dec_en = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            set_cfg(vecs[i].duty, vecs[i].len, 5, vecs[i].exp_in);
            vp = valid_pulses;
            drive_low(vecs[i].gap);
            drive_frame(8'(vecs[i].pat), vecs[i].len, vecs[i].duty);
            end_tick = tick;
            drive_low(6);
            exp_frames++;
            if (vecs[i].exp_match == 0) exp_errs++;
            check($sformatf("vec%0d_pulses", i), valid_pulses - vp, 1);
            check($sformatf("vec%0d_pat", i), 32'(pat_out), vecs[i].exp_pat);
            check($sformatf("vec%0d_match", i), 32'(pat_match), vecs[i].exp_match);
            check($sformatf("vec%0d_frames", i), 32'(frame_cnt), exp_frames);
            check($sformatf("vec%0d_errs", i), 32'(err_cnt), exp_errs);
            check($sformatf("vec%0d_latency", i), last_valid_tick - end_tick, SYNC_LAT + 1);
        end

        // Too-short gap: error flagged, following frame still decoded.
        set_cfg(3, 4, 5, 8'h0B);
        vp = valid_pulses;
        gp = gap_pulses;
        drive_low(10);
        drive_frame(8'h0B, 4, 3);
        drive_low(2);
        s2 = tick + 1;
        drive_frame(8'h0B, 4, 3);
        drive_low(6);
        exp_frames += 2;
        exp_errs   += 1;
        check("gap_err_pulses", gap_pulses - gp, 1);
        check("gap_err_tick",   last_gerr_tick - s2, SYNC_LAT);
        check("gap_valid_pulses", valid_pulses - vp, 2);
        check("gap_frames", 32'(frame_cnt), exp_frames);
        check("gap_errs",   32'(err_cnt), exp_errs);
        check("gap_pat",    32'(pat_out), 8'h0B);

        // dec_en dropped mid-frame: partial frame discarded, counters hold.
        vp = valid_pulses;
        drive_low(10);
        for (int j = 0; j < 8; j++) drive(j < 4 ? 1'b1 : 1'b1);  // bits 0 and 1 of 1011
        check("abort_busy_active", 32'(busy), 1);
        dec_en = 1'b0;
        drive(1'b0); drive(1'b0); drive(1'b0); drive(1'b0);     // bit 2 = 0
        check("abort_busy_idle", 32'(busy), 0);
        drive(1'b1); drive(1'b1); drive(1'b1); drive(1'b1);     // bit 3 = 1
        drive_low(6);
        check("abort_no_valid", valid_pulses - vp, 0);
        check("abort_frames",   32'(frame_cnt), exp_frames);
        dec_en = 1'b1;
        drive_low(10);
        drive_frame(8'h0B, 4, 3);
        drive_low(6);
        exp_frames++;
        check("reen_valid",  valid_pulses - vp, 1);
        check("reen_pat",    32'(pat_out), 8'h0B);
        check("reen_frames", 32'(frame_cnt), exp_frames);

        // Randomized waveform against the frame-level model.
        do_reset();
        ev_q.delete();
        gerr_q.delete();
        tick = -1;
        for (int seg = 0; seg < 3; seg++) begin
            cur_duty = $urandom_range(0, 4);
            cur_len  = $urandom_range(0, 10);
            cur_mg   = $urandom_range(1, 6);
            cur_exp  = ($urandom & 8'hFF) | 1;
            set_cfg(cur_duty, cur_len, cur_mg, cur_exp);
            for (int i = 0; i < 20; i++) rnd_drive(1'b0);
            for (int f = 0; f < 8; f++) begin
                logic [7:0] pat;
                int         gl;
                pat = ($urandom_range(0, 1) == 1) ? 8'(cur_exp) : (8'($urandom) | 8'h01);
                for (int k = 0; k < model_len(cur_len); k++)
                    for (int j = 0; j <= cur_duty; j++) rnd_drive(pat[k]);
                gl = $urandom_range(1, 8);
                for (int i = 0; i < gl; i++) rnd_drive(1'b0);
            end
        end
        for (int i = 0; i < 20; i++) rnd_drive(1'b0);

        // Model: find frame starts as low->high steps outside a frame body,
        // sample mid-bit, count gap lows since the previous frame ended.
        begin
            int  n, pos, prev_end, mg_prev, a, s, p_len, per, e, low;
            bit  in_gap;
            int  p, msk;
            ev_t xe;
            n = line_q.size();
            pos = 0; prev_end = 0; mg_prev = 0; in_gap = 0;
            m_frames = 0; m_errs = 0;
            while (1) begin
                a = -1;
                for (int i = pos; i < n - 1; i++) begin
                    if (line_q[i] == 0 && line_q[i+1] == 1) begin
                        a = i;
                        break;
                    end
                end
                if (a < 0) break;
                s = a + 1;
                if (in_gap) begin
                    low = 0;
                    for (int i = prev_end; i <= a; i++) if (line_q[i] == 0) low++;
                    if (low < mg_prev) begin
                        xg.push_back(s + SYNC_LAT);
                        m_errs++;
                    end
                end
                p_len = model_len(cl_q[s]);
                per   = cd_q[s] + 1;
                e     = s + p_len * per;
                if (e > n) break;
                p = 0;
                for (int k = 0; k < p_len; k++)
                    if (line_q[s + k * per + cd_q[s] / 2]) p = p | (1 << k);
                msk  = (1 << p_len) - 1;
                xe.t = e + SYNC_LAT;
                xe.p = 8'(p);
                xe.m = ((p ^ ce_q[s]) & msk) == 0;
                xq.push_back(xe);
                m_frames++;
                if (!xe.m) m_errs++;
                mg_prev  = cm_q[s];
                prev_end = e;
                pos      = e;
                in_gap   = 1;
            end
        end
        check("rnd_valid_count", ev_q.size(), xq.size());
        for (int i = 0; i < ev_q.size() && i < xq.size(); i++) begin
            check($sformatf("rnd%0d_tick", i),  ev_q[i].t, xq[i].t);
            check($sformatf("rnd%0d_pat", i),   32'(ev_q[i].p), 32'(xq[i].p));
            check($sformatf("rnd%0d_match", i), 32'(ev_q[i].m), 32'(xq[i].m));
        end
        check("rnd_gap_err_count", gerr_q.size(), xg.size());
        for (int i = 0; i < gerr_q.size() && i < xg.size(); i++)
            check($sformatf("rnd_gerr%0d_tick", i), gerr_q[i], xg[i]);
        check("rnd_frames", 32'(frame_cnt), m_frames);
        check("rnd_errs",   32'(err_cnt), (m_errs > 255) ? 255 : m_errs);

        // 260 mismatching one-bit frames: err_cnt saturates.
        do_reset();
        set_cfg(0, 1, 0, 8'h00);
        vp = valid_pulses;
        drive_low(4);
        for (int f = 0; f < 260; f++) begin
            drive(1'b1);
            drive(1'b0);
            drive(1'b0);
        end
        drive_low(6);
        check("sat_valid_pulses", valid_pulses - vp, 260);
        check("sat_frames", 32'(frame_cnt), 260);
        check("sat_errs",   32'(err_cnt), 8'hFF);
        check("sat_pat",    32'(pat_out), 8'h01);

        // Reset in the middle of a frame clears every output.
        set_cfg(3, 4, 5, 8'h0B);
        drive_low(4);
        for (int j = 0; j < 6; j++) drive(1'b1);
        check("midrst_busy_before", 32'(busy), 1);
        rst = 1'b1;
        drive(1'b1);
        check("midrst_pat_out", 32'(pat_out), 0);
        check("midrst_valid",   32'(pat_valid), 0);
        check("midrst_match",   32'(pat_match), 0);
        check("midrst_gap_err", 32'(gap_err), 0);
        check("midrst_frames",  32'(frame_cnt), 0);
        check("midrst_errs",    32'(err_cnt), 0);
        check("midrst_busy",    32'(busy), 0);
        rst = 1'b0;
        drive_low(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
